// File: rtl/sparc_boot_loader_if.sv
// rtl/sparc_boot_loader_if.sv - program stream and RAM byte-write bus for the boot loader
interface sparc_boot_loader_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  prog_valid;
  logic                  prog_ready;
  logic [31:0]           prog_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;

  // Host side: supplies instruction words, observes the RAM write port.
  modport master (
    output prog_valid, prog_data,
    input  prog_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side: accepts instruction words, drives the RAM write port.
  modport slave (
    input  prog_valid, prog_data,
    output prog_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sparc_boot_loader.sv
// rtl/sparc_boot_loader.sv - program loader and run sequencer for the SPARC datapath/control pair
module sparc_boot_loader #(
  parameter int NUM_WORDS   = 2,
  parameter int ADDR_WIDTH  = 9,
  parameter int BASE_ADDR   = 0,
  parameter int HOLD_CYCLES = 1,
  parameter int RUN_CYCLES  = 50
) (
  input  logic                 Clk,
  input  logic                 RESET_n,
  input  logic                 start,
  sparc_boot_loader_if.slave   bus,
  output logic                 cpu_reset,
  input  logic                 cpu_halt,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [15:0]          word_count,
  output logic [31:0]          cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_HOLD, S_RUN, S_DONE
  } state_t;

  state_t                state, state_next;
  logic [23:0]           data_q;      // low three bytes of the word being written
  logic [1:0]            byte_idx;
  logic [15:0]           hold_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q;

  logic [15:0]           word_count_inc;
  logic [31:0]           cycle_count_inc;
  logic                  last_byte;
  logic                  last_word;
  logic                  hold_last;
  logic                  run_last;
  logic [ADDR_WIDTH-1:0] word_base;
  logic [7:0]            next_byte;

  logic o_prog_ready, o_mem_we, o_cpu_reset, o_busy, o_done;

  assign word_count_inc  = word_count + 16'd1;
  assign cycle_count_inc = cycle_count + 32'd1;
  assign last_byte       = (byte_idx == 2'd3);
  assign last_word       = (word_count_inc == 16'(NUM_WORDS));
  assign hold_last       = (hold_cnt == 16'(HOLD_CYCLES - 1));
  assign run_last        = (cycle_count_inc == 32'(RUN_CYCLES));
  // Byte address of byte 0 of the current word; truncation gives the silent wrap.
  assign word_base       = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({word_count, 2'b00});
  // Big-endian order: the byte following the one currently on the bus.
  assign next_byte       = (byte_idx == 2'd0) ? data_q[23:16] :
                           (byte_idx == 2'd1) ? data_q[15:8]  : data_q[7:0];

  // State register.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  if (bus.prog_valid) state_next = S_WRITE;
      S_WRITE: if (last_byte) state_next = last_word ? S_HOLD : S_LOAD;
      S_HOLD:  if (hold_last) state_next = S_RUN;
      S_RUN:   if (cpu_halt || run_last) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  // Control outputs decoded from the registered state only.
  always_comb begin
    o_prog_ready = 1'b0;
    o_mem_we     = 1'b0;
    o_cpu_reset  = 1'b1;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (state)
      S_LOAD:  begin o_prog_ready = 1'b1; o_busy = 1'b1; end
      S_WRITE: begin o_mem_we = 1'b1; o_busy = 1'b1; end
      S_HOLD:  o_busy = 1'b1;
      S_RUN:   begin o_cpu_reset = 1'b0; o_busy = 1'b1; end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.prog_ready = o_prog_ready;
  assign bus.mem_we     = o_mem_we;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign cpu_reset      = o_cpu_reset;
  assign busy           = o_busy;
  assign done           = o_done;

  // Datapath: word capture, byte stepping, hold/run counters and completion status.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      data_q      <= '0;
      byte_idx    <= '0;
      hold_cnt    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      word_count  <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            word_count  <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.prog_valid) begin
            data_q   <= bus.prog_data[23:0];
            byte_idx <= 2'd0;
            addr_q   <= word_base;
            wdata_q  <= bus.prog_data[31:24];
          end
        end
        S_WRITE: begin
          if (last_byte) begin
            word_count <= word_count_inc;
            hold_cnt   <= '0;
          end else begin
            byte_idx <= byte_idx + 2'd1;
            addr_q   <= addr_q + 1'b1;
            wdata_q  <= next_byte;
          end
        end
        S_HOLD: hold_cnt <= hold_cnt + 16'd1;
        S_RUN: begin
          cycle_count <= cycle_count_inc;
          // Halt takes priority when it lands on the budget cycle.
          if (!cpu_halt && run_last) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
